nzr_bit_gen: RTL and testbench



---
 rtl/nzr_bit_gen_pkg.sv | 23 ++
 rtl/nzr_bit_gen.sv | 77 +++++++
 tb/tb_nzr_bit_gen.sv | 220 ++++++++++++++++++++++
 3 files changed

// File: rtl/nzr_bit_gen_pkg.sv
// Shared WS2812B line-coding definitions.
// Used by the NZR bit generator and the GRB sequencer.
package nzr_bit_gen_pkg;

    localparam int CLK_PER_BIT = 128;
    localparam int T0H         = 40;
    localparam int T1H         = 80;

    localparam logic [1:0] QM_ZERO  = 2'b00;
    localparam logic [1:0] QM_ONE   = 2'b01;
    localparam logic [1:0] QM_RESET = 2'b10;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } st_t;

    // 00/01 carry data; 10/11 both park the line
    function automatic logic is_data(input logic [1:0] m);
        return !m[1];
    endfunction

endpackage

// File: rtl/nzr_bit_gen.sv
// WS2812B NZR serial encoder: one bit period per qmode sample,
// high time chosen by the latched mode, bdone in the last clock.
module nzr_bit_gen #(
    parameter int CLK_PER_BIT = nzr_bit_gen_pkg::CLK_PER_BIT,
    parameter int T0H         = nzr_bit_gen_pkg::T0H,
    parameter int T1H         = nzr_bit_gen_pkg::T1H,
    parameter int CNT_W       = 8
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [1:0] qmode,
    input  logic       StartCoding,
    output logic       bdone,
    output logic       dout,
    output logic       busy
);
    import nzr_bit_gen_pkg::*;

    if (!(T0H > 0 && T0H < T1H && T1H < CLK_PER_BIT &&
          CLK_PER_BIT >= 4 && CLK_PER_BIT <= 255 &&
          (2 ** CNT_W) >= CLK_PER_BIT)) begin : g_bad_timing
        $error("nzr_bit_gen: illegal timing parameters");
    end

    localparam logic [CNT_W-1:0] LAST = CNT_W'(CLK_PER_BIT - 1);
    localparam logic [CNT_W-1:0] HI0  = CNT_W'(T0H);
    localparam logic [CNT_W-1:0] HI1  = CNT_W'(T1H);

    st_t              st, st_n;
    logic [CNT_W-1:0] cnt, cnt_n;
    logic [1:0]       mode_q, mode_n, mode_eff;
    logic             dout_n;

    always_ff @(posedge clk) begin
        if (reset) begin
            st     <= ST_IDLE;
            cnt    <= '0;
            mode_q <= QM_RESET;
            dout   <= 1'b0;
        end else begin
            st     <= st_n;
            cnt    <= cnt_n;
            mode_q <= mode_n;
            dout   <= dout_n;
        end
    end

    always_comb begin
        st_n     = st;
        cnt_n    = cnt;
        mode_n   = mode_q;
        dout_n   = 1'b0;
        mode_eff = (cnt == '0) ? qmode : mode_q;
        if (StartCoding) begin
            // restart aborts any bit in flight, even a RESET sample
            st_n  = ST_RUN;
            cnt_n = '0;
        end else if (st == ST_RUN) begin
            if (cnt == '0) begin
                mode_n = qmode;
            end
            if (cnt == '0 && !is_data(qmode)) begin
                st_n  = ST_IDLE;
                cnt_n = '0;
            end else begin
                dout_n = cnt < (mode_eff[0] ? HI1 : HI0);
                cnt_n  = (cnt == LAST) ? '0 : cnt + 1'b1;
            end
        end else begin
            cnt_n = '0;
        end
    end

    assign bdone = (st == ST_RUN) && (cnt == LAST) && is_data(mode_q);
    assign busy  = (st == ST_RUN);

endmodule

// File: tb/tb_nzr_bit_gen.sv
// Scoreboard bench for nzr_bit_gen: expected bit periods are queued
// at stream start and matched against each bdone by a monitor.
module tb_nzr_bit_gen;
    localparam int CPB = 128;
    localparam int W0  = 40;
    localparam int W1  = 80;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [1:0] qmode = 2'b00;
    logic       StartCoding = 1'b0;
    logic       bdone, dout, busy;

    int cyc = 0;
    int errors = 0;
    int checks = 0;

    typedef struct {
        int bd;
        int width;
        int rise;
    } exp_t;

    exp_t exp_q[$];
    logic bits[$];

    nzr_bit_gen dut (
        .clk(clk),
        .reset(reset),
        .qmode(qmode),
        .StartCoding(StartCoding),
        .bdone(bdone),
        .dout(dout),
        .busy(busy)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #700000;
        $display("FAIL watchdog: cycle %0d reached, limit exceeded", cyc);
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input int got, input int want);
        checks++;
        if (got != want) begin
            errors++;
            $display("FAIL %s: got %0d want %0d (cycle %0d)", name, got, want, cyc);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Matches each bdone against the oldest queued bit period
    task automatic monitor();
        int hi_cnt = 0;
        int rise = -1;
        exp_t e;
        forever begin
            @(negedge clk);
            if (dout) begin
                if (rise < 0) rise = cyc;
                hi_cnt++;
            end
            if (bdone) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_bdone", 1, 0);
                end else begin
                    e = exp_q.pop_front();
                    check("bdone_cycle", cyc, e.bd);
                    check("high_width", hi_cnt, e.width);
                    check("rise_cycle", rise, e.rise);
                end
            end
            if (bdone || StartCoding || reset) begin
                hi_cnt = 0;
                rise = -1;
            end
        end
    endtask

    task automatic idle_check(input int n, input string name);
        int bad = 0;
        repeat (n) begin
            step();
            if (dout || busy || bdone) bad++;
        end
        check(name, bad, 0);
    endtask

    // Leaves the bench in cycle j+1 with qmode still holding qm
    task automatic start_pulse(input logic [1:0] qm, output int j);
        StartCoding = 1'b1;
        qmode = qm;
        j = cyc;
        step();
        StartCoding = 1'b0;
    endtask

    // Entered in cycle j+1 of a StartCoding issued in cycle j
    task automatic run_bits(input int j, input logic [1:0] endm);
        int n = bits.size();
        int waited;
        for (int k = 0; k < n; k++) begin
            exp_q.push_back('{bd: j + CPB * (k + 1),
                              width: bits[k] ? W1 : W0,
                              rise: j + 2 + CPB * k});
        end
        step();
        qmode = 2'($urandom_range(0, 3));
        for (int k = 0; k < n; k++) begin
            waited = 0;
            while (!bdone && waited < 2 * CPB) begin
                step();
                qmode = 2'($urandom_range(0, 3));
                waited++;
            end
            if (!bdone) begin
                check("bdone_timeout", waited, CPB);
                exp_q.delete();
                return;
            end
            step();
            qmode = (k + 1 < n) ? {1'b0, bits[k + 1]} : endm;
            step();
            qmode = 2'($urandom_range(0, 3));
        end
        check("busy_after_end", int'(busy), 0);
        idle_check(10, "idle_after_end");
    endtask

    initial begin
        int j;
        int n;
        fork
            monitor();
        join_none

        repeat (3) @(posedge clk);
        #1;
        check("reset_dout", int'(dout), 0);
        check("reset_busy", int'(busy), 0);
        reset = 1'b0;
        idle_check(5, "idle_after_reset");
        while (cyc < 10) step();

        bits = '{1'b0};
        start_pulse(2'b00, j);
        check("busy_first_cycle", int'(busy), 1);
        check("dout_first_cycle", int'(dout), 0);
        run_bits(j, 2'b10);

        bits = '{1'b1, 1'b0, 1'b1};
        start_pulse(2'b01, j);
        run_bits(j, 2'b10);

        bits = '{1'b1};
        start_pulse(2'b01, j);
        run_bits(j, 2'b11);

        // illegal mode at the first sample parks the line
        start_pulse(2'b11, j);
        check("busy_on_illegal", int'(busy), 1);
        step();
        check("busy_after_illegal", int'(busy), 0);
        idle_check(140, "illegal_no_pulse");

        // restart at cnt=60 of a 1 bit
        start_pulse(2'b01, j);
        repeat (60) step();
        check("dout_mid_abort", int'(dout), 1);
        bits = '{1'b0, 1'b1};
        start_pulse(2'b00, j);
        run_bits(j, 2'b10);

        // StartCoding coincides with a RESET sample
        StartCoding = 1'b1;
        qmode = 2'b10;
        step();
        qmode = 2'b10;
        j = cyc;
        step();
        StartCoding = 1'b0;
        bits = '{1'b1, 1'b1};
        qmode = 2'b01;
        check("busy_collision", int'(busy), 1);
        run_bits(j, 2'b10);

        // synchronous reset mid-bit
        start_pulse(2'b01, j);
        repeat (30) step();
        check("dout_before_reset", int'(dout), 1);
        reset = 1'b1;
        step();
        check("dout_in_reset", int'(dout), 0);
        check("busy_in_reset", int'(busy), 0);
        reset = 1'b0;
        idle_check(150, "idle_after_mid_reset");

        for (int r = 0; r < 6; r++) begin
            idle_check($urandom_range(2, 20), "idle_gap");
            n = $urandom_range(1, 4);
            bits.delete();
            for (int k = 0; k < n; k++) bits.push_back(1'($urandom_range(0, 1)));
            start_pulse({1'b0, bits[0]}, j);
            run_bits(j, 2'($urandom_range(2, 3)));
        end

        repeat (5) step();
        check("queue_drained", exp_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
